// File: rtl/foreground_config_scheduler_pkg.sv
// rtl/foreground_config_scheduler_pkg.sv - shared constants and state type for the foreground config scheduler
package foreground_config_scheduler_pkg;

  localparam logic [1:0] SCALE_OFF     = 2'b00;
  localparam logic [1:0] SCALE_QUARTER = 2'b01;
  localparam logic [1:0] SCALE_HALF    = 2'b10;
  localparam logic [1:0] SCALE_FULL    = 2'b11;

  localparam logic [2:0] CMD_SCALE    = 3'd0;
  localparam logic [2:0] CMD_OFFSET_X = 3'd1;
  localparam logic [2:0] CMD_OFFSET_Y = 3'd2;
  localparam logic [2:0] CMD_VEL_X    = 3'd3;
  localparam logic [2:0] CMD_VEL_Y    = 3'd4;
  localparam logic [2:0] CMD_COMMIT   = 3'd5;
  localparam logic [2:0] CMD_ABORT    = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

endpackage

// File: rtl/foreground_config_scheduler_stepper.sv
// rtl/foreground_config_scheduler_stepper.sv - one-axis offset + velocity step clamped to +/-LIMIT
module offset_saturating_stepper #(
  parameter int PRECISION = 11,
  parameter int LIMIT     = 800
) (
  input  logic signed [PRECISION:0] offset,
  input  logic signed [PRECISION:0] velocity,
  output logic signed [PRECISION:0] next_offset
);

  localparam logic signed [PRECISION+1:0] HI = (PRECISION+2)'(LIMIT);
  localparam logic signed [PRECISION+1:0] LO = -HI;

  logic signed [PRECISION+1:0] sum;

  // One extra bit so the raw sum never wraps before the clamp sees it.
  always_comb begin
    sum = $signed({offset[PRECISION], offset}) + $signed({velocity[PRECISION], velocity});
    if (sum > HI) begin
      next_offset = HI[PRECISION:0];
    end else if (sum < LO) begin
      next_offset = LO[PRECISION:0];
    end else begin
      next_offset = sum[PRECISION:0];
    end
  end

endmodule

// File: rtl/foreground_config_scheduler.sv
// rtl/foreground_config_scheduler.sv - shadowed foreground scale/offset registers committed at frame boundaries
module foreground_config_scheduler
  import foreground_config_scheduler_pkg::*;
#(
  parameter int RESOLUTION_X = 800,
  parameter int RESOLUTION_Y = 600,
  parameter int PRECISION    = 11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_addr,
  input  logic [PRECISION:0]          cmd_data,
  input  logic                        frame_end,
  output logic [1:0]                  ctrl_foreground_scale,
  output logic signed [PRECISION:0]   fg_offset_x,
  output logic signed [PRECISION:0]   fg_offset_y,
  output logic                        commit_pending,
  output logic                        apply_done
);

  state_t state, state_next;

  logic [1:0]                sh_scale;
  logic signed [PRECISION:0] sh_off_x, sh_off_y, sh_vel_x, sh_vel_y;
  logic signed [PRECISION:0] vel_x, vel_y;
  logic signed [PRECISION:0] step_x, step_y;
  logic                      accept;

  assign cmd_ready      = (state != ST_APPLY);
  assign commit_pending = (state == ST_ARMED);
  assign accept         = cmd_valid && cmd_ready;

  // A frame boundary wins over a same-cycle abort once a commit is armed.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept && cmd_addr == CMD_COMMIT) state_next = ST_ARMED;
      ST_ARMED: begin
        if (frame_end)                                state_next = ST_APPLY;
        else if (accept && cmd_addr == CMD_ABORT)     state_next = ST_IDLE;
      end
      ST_APPLY: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      apply_done <= 1'b0;
    end else begin
      state      <= state_next;
      apply_done <= (state == ST_APPLY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_scale <= SCALE_FULL;
      sh_off_x <= '0;
      sh_off_y <= '0;
      sh_vel_x <= '0;
      sh_vel_y <= '0;
    end else if (accept) begin
      case (cmd_addr)
        CMD_SCALE:    sh_scale <= cmd_data[1:0];
        CMD_OFFSET_X: sh_off_x <= cmd_data;
        CMD_OFFSET_Y: sh_off_y <= cmd_data;
        CMD_VEL_X:    sh_vel_x <= cmd_data;
        CMD_VEL_Y:    sh_vel_y <= cmd_data;
        default:      ;
      endcase
    end
  end

  offset_saturating_stepper #(.PRECISION(PRECISION), .LIMIT(RESOLUTION_X)) u_step_x (
    .offset      (fg_offset_x),
    .velocity    (vel_x),
    .next_offset (step_x)
  );

  offset_saturating_stepper #(.PRECISION(PRECISION), .LIMIT(RESOLUTION_Y)) u_step_y (
    .offset      (fg_offset_y),
    .velocity    (vel_y),
    .next_offset (step_y)
  );

  // Committed offsets pass through unclamped; only the pan step saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_foreground_scale <= SCALE_FULL;
      fg_offset_x           <= '0;
      fg_offset_y           <= '0;
      vel_x                 <= '0;
      vel_y                 <= '0;
    end else if (state == ST_APPLY) begin
      ctrl_foreground_scale <= sh_scale;
      fg_offset_x           <= sh_off_x;
      fg_offset_y           <= sh_off_y;
      vel_x                 <= sh_vel_x;
      vel_y                 <= sh_vel_y;
    end else if (state == ST_IDLE && frame_end) begin
      fg_offset_x <= step_x;
      fg_offset_y <= step_y;
    end
  end

endmodule

// File: tb/tb_foreground_config_scheduler.sv
// tb/tb_foreground_config_scheduler.sv - self-checking bench for foreground_config_scheduler
module tb_foreground_config_scheduler;

  localparam int RES_X = 800;
  localparam int RES_Y = 600;
  localparam int P     = 11;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_addr;
  logic [P:0]        cmd_data;
  logic              frame_end;
  logic [1:0]        ctrl_foreground_scale;
  logic signed [P:0] fg_offset_x;
  logic signed [P:0] fg_offset_y;
  logic              commit_pending;
  logic              apply_done;

  int checks = 0;
  int errors = 0;

  // reference model: register contents as plain integers
  int  sh[5];        // 0 scale, 1 off_x, 2 off_y, 3 vel_x, 4 vel_y
  int  m_scale, m_x, m_y, m_vx, m_vy;
  bit  m_armed, m_copy_now, m_done;

  foreground_config_scheduler #(.RESOLUTION_X(RES_X), .RESOLUTION_Y(RES_Y), .PRECISION(P)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_addr              (cmd_addr),
    .cmd_data              (cmd_data),
    .frame_end             (frame_end),
    .ctrl_foreground_scale (ctrl_foreground_scale),
    .fg_offset_x           (fg_offset_x),
    .fg_offset_y           (fg_offset_y),
    .commit_pending        (commit_pending),
    .apply_done            (apply_done)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v, input int lim);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_reset();
    sh[0] = 3; sh[1] = 0; sh[2] = 0; sh[3] = 0; sh[4] = 0;
    m_scale = 3; m_x = 0; m_y = 0; m_vx = 0; m_vy = 0;
    m_armed = 0; m_copy_now = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit v, input logic [2:0] a, input logic [P:0] d, input bit fe);
    bit acc;
    int sd;
    acc    = v && !m_copy_now;
    sd     = int'($signed(d));
    m_done = m_copy_now;
    if (m_copy_now) begin
      m_scale = sh[0]; m_x = sh[1]; m_y = sh[2]; m_vx = sh[3]; m_vy = sh[4];
      m_copy_now = 0;
    end else begin
      if (fe && !m_armed) begin
        m_x = sat(m_x + m_vx, RES_X);
        m_y = sat(m_y + m_vy, RES_Y);
      end
      if (m_armed && fe) begin
        m_copy_now = 1;
        m_armed    = 0;
      end else if (acc && a == 3'd5) begin
        m_armed = 1;
      end else if (acc && a == 3'd6) begin
        m_armed = 0;
      end
      if (acc && a == 3'd0) sh[0] = int'(d[1:0]);
      else if (acc && a <= 3'd4) sh[a] = sd;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".scale"},   32'(ctrl_foreground_scale), 32'(m_scale));
    chk({tag, ".off_x"},   32'(fg_offset_x),           32'(m_x));
    chk({tag, ".off_y"},   32'(fg_offset_y),           32'(m_y));
    chk({tag, ".ready"},   32'(cmd_ready),             32'(!m_copy_now));
    chk({tag, ".pending"}, 32'(commit_pending),        32'(m_armed));
    chk({tag, ".done"},    32'(apply_done),            32'(m_done));
  endtask

  task automatic cyc(input string tag, input bit v, input logic [2:0] a, input logic [P:0] d, input bit fe);
    cmd_valid = v; cmd_addr = a; cmd_data = d; frame_end = fe;
    @(posedge clk);
    model_edge(v, a, d, fe);
    #1;
    cmd_valid = 1'b0; frame_end = 1'b0;
    check_all(tag);
  endtask

  task automatic wr(input string tag, input logic [2:0] a, input int d);
    cyc(tag, 1'b1, a, (P+1)'(d), 1'b0);
  endtask

  task automatic fe(input string tag);
    cyc(tag, 1'b0, 3'd0, '0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; frame_end = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all("reset");

    // commit at a frame boundary long after the writes
    wr("w_scale", 3'd0, 2);
    wr("w_offx", 3'd1, 50);
    wr("w_offy", 3'd2, -20);
    wr("commit", 3'd5, 0);
    for (int i = 0; i < 100; i++) cyc("wait", 1'b0, 3'd0, '0, 1'b0);
    fe("fe_arm");
    cyc("apply", 1'b0, 3'd0, '0, 1'b0);
    chk("applied_scale", 32'(ctrl_foreground_scale), 32'd2);
    chk("applied_x", 32'(fg_offset_x), 32'd50);
    chk("applied_y", 32'(fg_offset_y), -32'sd20);
    cyc("after", 1'b0, 3'd0, '0, 1'b0);

    // positive pan with clamp, then negative pan with clamp
    wr("w_offx0", 3'd1, 0);
    wr("w_velx", 3'd3, 300);
    wr("commit2", 3'd5, 0);
    fe("fe2");
    cyc("apply2", 1'b0, 3'd0, '0, 1'b0);
    fe("pan1"); chk("pan1_x", 32'(fg_offset_x), 32'd300);
    fe("pan2"); chk("pan2_x", 32'(fg_offset_x), 32'd600);
    fe("pan3"); chk("pan3_x", 32'(fg_offset_x), 32'd800);
    wr("w_offx0b", 3'd1, 0);
    wr("w_velxn", 3'd3, -700);
    wr("commit3", 3'd5, 0);
    fe("fe3");
    cyc("apply3", 1'b0, 3'd0, '0, 1'b0);
    fe("npan1"); chk("npan1_x", 32'(fg_offset_x), -32'sd700);
    fe("npan2"); chk("npan2_x", 32'(fg_offset_x), -32'sd800);
    wr("w_velx0", 3'd3, 0);

    // abort discards the commit but keeps the shadows
    wr("w_scale1", 3'd0, 1);
    wr("commit4", 3'd5, 0);
    wr("abort", 3'd6, 0);
    fe("fe_abort");
    cyc("abort_idle", 1'b0, 3'd0, '0, 1'b0);
    wr("commit5", 3'd5, 0);
    fe("fe5");
    cyc("apply5", 1'b0, 3'd0, '0, 1'b0);
    chk("late_scale", 32'(ctrl_foreground_scale), 32'd1);

    // write landing on the frame_end edge while armed
    wr("commit6", 3'd5, 0);
    cyc("wr_fe", 1'b1, 3'd1, 12'd123, 1'b1);
    chk("apply_ready", 32'(cmd_ready), 32'd0);
    cyc("apply6", 1'b1, 3'd1, 12'd7, 1'b0);
    chk("wr_fe_x", 32'(fg_offset_x), 32'd123);

    // commit coinciding with frame_end in idle: step now, apply next frame
    wr("w_vely", 3'd4, 0);
    cyc("commit_fe", 1'b1, 3'd5, '0, 1'b1);
    fe("fe7");
    cyc("apply7", 1'b0, 3'd0, '0, 1'b0);

    // asynchronous reset while armed
    wr("w_scale_q", 3'd0, 1);
    wr("commit8", 3'd5, 0);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    fe("fe_after_rst");
    cyc("post_rst", 1'b0, 3'd0, '0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit          v, f;
      logic [2:0]  a;
      logic [P:0]  d;
      v = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 9) == 0);
      a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) d = (P+1)'($urandom_range(0, 4095));
      else                           d = (P+1)'($urandom_range(0, 1200) - 600);
      cyc("rand", v, a, d, f);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
